riscv_muldiv: RTL and testbench
===============================

RISCV_MULDIV -- requirements
Module: riscv_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand and result width in bits.
REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: iteration bits retired per busy cycle; legal values 1, 2, 4; XLEN SHALL be divisible by it.
REQ-003 SHALL have port clk_in, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n_in, input, 1: reset; synchronous, active-low.
REQ-005 SHALL have port valid_in, input, 1: request present.
REQ-006 SHALL have port ready_out, output, 1: unit can accept a request.
REQ-007 SHALL have port func_in, input, 3: RV32M funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-008 SHALL have port a_in, input, XLEN: rs1 operand.
REQ-009 SHALL have port b_in, input, XLEN: rs2 operand.
REQ-010 SHALL have port flush_in, input, 1: pipeline kill; abandons any operation in flight.
REQ-011 SHALL have port valid_out, output, 1: result_out holds a completed result.
REQ-012 SHALL have port ready_in, input, 1: consumer accepts the result.
REQ-013 SHALL have port result_out, output, XLEN: result.
REQ-014 SHALL have port busy_out, output, 1: high in any state except IDLE.

Function
REQ-015 SHALL implement states IDLE, BUSY, FIX and DONE.
REQ-016 SHALL assert ready_out only in IDLE; a request is accepted on an edge where valid_in && ready_out && !flush_in.
REQ-017 SHALL latch func_in, a_in and b_in on acceptance; later input changes SHALL have no effect.
REQ-018 SHALL, on acceptance: enter DONE directly for a special case (REQ-023, REQ-024); otherwise enter BUSY with step counter N = XLEN/BITS_PER_CYCLE.
REQ-019 SHALL, in BUSY, perform one shift-add (multiply) or restoring-subtract (divide) step of BITS_PER_CYCLE bits per edge on operand magnitudes, decrement the counter, and enter FIX after the Nth step.
REQ-020 SHALL, in FIX, apply sign correction and select the low/high product half or quotient/remainder, then enter DONE after one edge.
REQ-021 SHALL give normal-path latency of N+2 edges from the accepting edge to valid_out high (34 for defaults), and special-case latency of 1.
REQ-022 SHALL hold valid_out high and result_out stable in DONE until an edge with ready_in high, then return to IDLE.
REQ-023 SHALL, on divide by zero, produce quotient all-ones (DIV/DIVU) and remainder = a_in (REM/REMU).
REQ-024 SHALL, on signed overflow (a_in = most-negative, b_in = all-ones, DIV/REM), produce quotient = a_in and remainder 0.
REQ-025 SHALL give the remainder the sign of the dividend and truncate the quotient toward zero.
REQ-026 SHALL treat MULHSU as rs1 signed, rs2 unsigned, and compute the full 2*XLEN-bit product internally.
REQ-027 SHALL, on flush_in high, enter IDLE on that edge from any state, deassert valid_out and discard the result; flush_in has priority over acceptance and over ready_in.
REQ-028 SHALL NOT accept a new request in the same cycle as a result handoff; the new request is accepted on the following edge at the earliest.

Reset
REQ-029 SHALL, on an edge with rst_n_in low, enter IDLE, clear the counter and operand registers, and drive valid_out=0, busy_out=0, result_out=0, ready_out=1 from the next cycle.
REQ-030 SHALL let reset override flush_in and any operation in flight, including mid-BUSY.

Structure
REQ-031 SHALL place the funct3 encodings as a muldiv_func_t typedef and the state enum in the shared riscv_constants package.
REQ-032 SHALL instantiate one combinational sub-module, riscv_muldiv_step, which performs a single BITS_PER_CYCLE iteration for both multiply and divide.

Verification
REQ-033 SHALL cover MUL with a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, valid_out exactly 34 edges after acceptance.
REQ-034 SHALL cover MULHU with a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-035 SHALL cover DIV with a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF.
REQ-036 SHALL cover DIVU with a=100, b=0 -> 0xFFFFFFFF after 1 edge; REMU -> 100; DIV with a=0x80000000, b=0xFFFFFFFF -> 0x80000000 after 1 edge; REM -> 0.
REQ-037 SHALL cover backpressure: ready_in held low for 5 cycles in DONE -> result_out and valid_out held stable, ready_out low; handoff, then the next request is accepted one edge later.
REQ-038 SHALL cover flush and reset: flush_in at BUSY step 10 -> IDLE next edge with no valid_out; rst_n_in low mid-BUSY -> all outputs at reset values; the same run repeated with BITS_PER_CYCLE=4 -> latency 10.

Source files
------------

// File: rtl/riscv_constants.sv
// Shared RV32M encodings and multiply/divide unit state type.
package riscv_constants;

  typedef enum logic [2:0] {
    FN_MUL    = 3'd0,
    FN_MULH   = 3'd1,
    FN_MULHSU = 3'd2,
    FN_MULHU  = 3'd3,
    FN_DIV    = 3'd4,
    FN_DIVU   = 3'd5,
    FN_REM    = 3'd6,
    FN_REMU   = 3'd7
  } muldiv_func_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_FIX,
    ST_DONE
  } muldiv_state_t;

  function automatic logic is_div(input muldiv_func_t f);
    return f[2];
  endfunction

  function automatic logic rs1_signed(input muldiv_func_t f);
    return (f == FN_MULH) || (f == FN_MULHSU) || (f == FN_DIV) || (f == FN_REM);
  endfunction

  function automatic logic rs2_signed(input muldiv_func_t f);
    return (f == FN_MULH) || (f == FN_DIV) || (f == FN_REM);
  endfunction

endpackage

// File: rtl/riscv_muldiv_step.sv
// One iteration of BITS bits: shift-add multiply or restoring divide on
// unsigned magnitudes held in a {high, low} accumulator.
module riscv_muldiv_step #(
  parameter int XLEN = 32,
  parameter int BITS = 1
) (
  input  logic              div_op,
  input  logic [XLEN-1:0]   operand,
  input  logic [2*XLEN-1:0] acc_in,
  output logic [2*XLEN-1:0] acc_out
);

  logic [BITS:0][2*XLEN-1:0] stage;

  assign stage[0] = acc_in;

  generate
    for (genvar gi = 0; gi < BITS; gi++) begin : g_bit
      logic [XLEN:0]   sum;
      logic [XLEN:0]   shifted;
      logic [XLEN-1:0] diff;
      logic [XLEN-1:0] rem_new;
      logic            ge;

      // Multiply: high half accumulates the multiplicand, whole word shifts right.
      assign sum     = {1'b0, stage[gi][2*XLEN-1:XLEN]} + (stage[gi][0] ? {1'b0, operand} : '0);
      // Divide: high half is the partial remainder, low half shifts quotient bits in.
      assign shifted = {stage[gi][2*XLEN-1:XLEN], stage[gi][XLEN-1]};
      assign ge      = shifted >= {1'b0, operand};
      assign diff    = shifted[XLEN-1:0] - operand;
      assign rem_new = ge ? diff : shifted[XLEN-1:0];

      assign stage[gi+1] = div_op ? {rem_new, stage[gi][XLEN-2:0], ge}
                                  : {sum, stage[gi][XLEN-1:1]};
    end
  endgenerate

  assign acc_out = stage[BITS];

endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes on both
// sides, flush support and single-edge handling of divide special cases.
module riscv_muldiv
  import riscv_constants::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [2:0]      func_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic            flush_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] result_out,
  output logic            busy_out
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_reg, state_next;
  muldiv_func_t      func_reg, func_new;
  logic [XLEN-1:0]   a_reg, b_reg, operand_reg, result_reg;
  logic [2*XLEN-1:0] acc_reg, acc_step;
  logic [CW-1:0]     count_reg;

  logic            accept, div_op;
  logic            a_neg_in, b_neg_in, div_zero, overflow, special;
  logic [XLEN-1:0] a_mag_in, b_mag_in, special_result;
  logic            a_neg_r, b_neg_r;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quo_raw, rem_raw, quo_fix, rem_fix, fix_result;

  // Request-side decode, evaluated on the raw inputs at the accepting edge.
  always_comb begin
    func_new       = muldiv_func_t'(func_in);
    a_neg_in       = rs1_signed(func_new) && a_in[XLEN-1];
    b_neg_in       = rs2_signed(func_new) && b_in[XLEN-1];
    a_mag_in       = a_neg_in ? -a_in : a_in;
    b_mag_in       = b_neg_in ? -b_in : b_in;
    div_zero       = (b_in == '0);
    overflow       = ((func_new == FN_DIV) || (func_new == FN_REM)) &&
                     (a_in == MOST_NEG) && (b_in == '1);
    special        = is_div(func_new) && (div_zero || overflow);
    // funct3 bit 1 distinguishes REM/REMU from DIV/DIVU.
    special_result = div_zero ? (func_new[1] ? a_in : '1)
                              : (func_new[1] ? '0 : a_in);
  end

  assign accept = (state_reg == ST_IDLE) && valid_in && !flush_in;
  assign div_op = is_div(func_reg);

  riscv_muldiv_step #(
    .XLEN (XLEN),
    .BITS (BITS_PER_CYCLE)
  ) u_step (
    .div_op  (div_op),
    .operand (operand_reg),
    .acc_in  (acc_reg),
    .acc_out (acc_step)
  );

  // Sign restoration from the latched operands.
  always_comb begin
    a_neg_r  = rs1_signed(func_reg) && a_reg[XLEN-1];
    b_neg_r  = rs2_signed(func_reg) && b_reg[XLEN-1];
    prod_fix = (a_neg_r ^ b_neg_r) ? -acc_reg : acc_reg;
    quo_raw  = acc_reg[XLEN-1:0];
    rem_raw  = acc_reg[2*XLEN-1:XLEN];
    quo_fix  = (a_neg_r ^ b_neg_r) ? -quo_raw : quo_raw;
    rem_fix  = a_neg_r ? -rem_raw : rem_raw;
    case (func_reg)
      FN_MUL:                        fix_result = prod_fix[XLEN-1:0];
      FN_MULH, FN_MULHSU, FN_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
      FN_DIV, FN_DIVU:               fix_result = quo_fix;
      default:                       fix_result = rem_fix;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = special ? ST_DONE : ST_BUSY;
      ST_BUSY: if (count_reg == CW'(1)) state_next = ST_FIX;
      ST_FIX:  state_next = ST_DONE;
      ST_DONE: if (ready_in) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
    if (flush_in) state_next = ST_IDLE;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) state_reg <= ST_IDLE;
    else           state_reg <= state_next;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      func_reg    <= FN_MUL;
      a_reg       <= '0;
      b_reg       <= '0;
      operand_reg <= '0;
      acc_reg     <= '0;
      count_reg   <= '0;
      result_reg  <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (accept) begin
          func_reg  <= func_new;
          a_reg     <= a_in;
          b_reg     <= b_in;
          count_reg <= CW'(STEPS);
          if (is_div(func_new)) begin
            acc_reg     <= {{XLEN{1'b0}}, a_mag_in};
            operand_reg <= b_mag_in;
          end else begin
            acc_reg     <= {{XLEN{1'b0}}, b_mag_in};
            operand_reg <= a_mag_in;
          end
          if (special) result_reg <= special_result;
        end
        ST_BUSY: begin
          acc_reg   <= acc_step;
          count_reg <= count_reg - CW'(1);
        end
        ST_FIX:  result_reg <= fix_result;
        default: ;
      endcase
    end
  end

  assign ready_out  = (state_reg == ST_IDLE);
  assign busy_out   = (state_reg != ST_IDLE);
  assign valid_out  = (state_reg == ST_DONE);
  assign result_out = result_reg;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Randomized bench for riscv_muldiv at BITS_PER_CYCLE 1 and 4 against an
// arithmetic reference model.
module tb_riscv_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  func_in;
  logic [31:0] a_in, b_in;
  logic        flush_in, ready_in;
  logic        valid1, valid4;
  logic        ready1, ready4, vout1, vout4, busy1, busy4;
  logic [31:0] result1, result4;
  logic        sel;
  logic        m_ready, m_valid, m_busy;
  logic [31:0] m_result;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  riscv_muldiv #(.XLEN(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid1), .ready_out(ready1),
    .func_in(func_in), .a_in(a_in), .b_in(b_in), .flush_in(flush_in),
    .valid_out(vout1), .ready_in(ready_in), .result_out(result1), .busy_out(busy1)
  );

  riscv_muldiv #(.XLEN(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk_in(clk), .rst_n_in(rst_n), .valid_in(valid4), .ready_out(ready4),
    .func_in(func_in), .a_in(a_in), .b_in(b_in), .flush_in(flush_in),
    .valid_out(vout4), .ready_in(ready_in), .result_out(result4), .busy_out(busy4)
  );

  assign m_ready  = sel ? ready4  : ready1;
  assign m_valid  = sel ? vout4   : vout1;
  assign m_busy   = sel ? busy4   : busy1;
  assign m_result = sel ? result4 : result1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 32'd0) ||
                    (((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = '0;
    case (f)
      3'd0: begin p = ua * ub; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
            else r = 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
            else r = 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  // Present a request on the selected unit and wait for it to be taken.
  task automatic present(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv);
    int n;
    @(negedge clk);
    func_in = f; a_in = av; b_in = bv;
    valid1 = !sel; valid4 = sel;
    n = 0;
    while (!m_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("accept_timeout", 64'(n), 64'd0);
    @(posedge clk);
    @(negedge clk);
    valid1 = 1'b0; valid4 = 1'b0;
    func_in = 3'($urandom); a_in = $urandom; b_in = $urandom;
  endtask

  task automatic do_op(input logic [2:0] f, input logic [31:0] av, input logic [31:0] bv, input int hold);
    int          lat, el;
    logic [31:0] exp;
    exp = ref_result(f, av, bv);
    el  = is_special(f, av, bv) ? 1 : (sel ? 8 : 32) + 2;
    present(f, av, bv);
    lat = 1;
    check("busy_after_accept", 64'(m_busy), 64'd1);
    check("ready_after_accept", 64'(m_ready), 64'd0);
    while (!m_valid && lat < 200) begin @(posedge clk); lat++; @(negedge clk); end
    check("latency", 64'(lat), 64'(el));
    check("result", 64'(m_result), 64'(exp));
    $display("op bpc=%0d f=%0d a=%h b=%h result=%h expect=%h lat=%0d",
             sel ? 4 : 1, f, av, bv, m_result, exp, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", 64'(m_valid), 64'd1);
      check("hold_result", 64'(m_result), 64'(exp));
      check("hold_ready", 64'(m_ready), 64'd0);
    end
    ready_in = 1'b1;
    @(posedge clk); @(negedge clk);
    ready_in = 1'b0;
    check("handoff_valid", 64'(m_valid), 64'd0);
    check("handoff_ready", 64'(m_ready), 64'd1);
  endtask

  task automatic random_ops(input int count);
    logic [2:0]  f;
    logic [31:0] av, bv;
    for (int i = 0; i < count; i++) begin
      f  = 3'($urandom_range(0, 7));
      av = $urandom;
      bv = $urandom;
      case ($urandom_range(0, 9))
        0: bv = 32'd0;
        1: begin av = 32'h8000_0000; bv = 32'hFFFF_FFFF; end
        2: bv = 32'($urandom_range(1, 15));
        3: av = 32'($urandom_range(0, 255));
        default: ;
      endcase
      do_op(f, av, bv, $urandom_range(0, 2));
    end
  endtask

  task automatic flush_test();
    logic seen;
    present(3'd0, $urandom, $urandom);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush_in = 1'b1;
    @(posedge clk); @(negedge clk);
    flush_in = 1'b0;
    check("flush_busy", 64'(m_busy), 64'd0);
    check("flush_ready", 64'(m_ready), 64'd1);
    check("flush_valid", 64'(m_valid), 64'd0);
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen = seen | m_valid; end
    check("flush_no_result", 64'(seen), 64'd0);
  endtask

  task automatic reset_test();
    present(3'd4, 32'h1234_5678, 32'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    check("rst_busy", 64'(m_busy), 64'd0);
    check("rst_valid", 64'(m_valid), 64'd0);
    check("rst_ready", 64'(m_ready), 64'd1);
    check("rst_result", 64'(m_result), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; func_in = '0; a_in = '0; b_in = '0;
    flush_in = 1'b0; ready_in = 1'b0; valid1 = 1'b0; valid4 = 1'b0; sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ready1", 64'(ready1), 64'd1);
    check("reset_busy1", 64'(busy1), 64'd0);
    check("reset_valid1", 64'(vout1), 64'd0);
    check("reset_result1", 64'(result1), 64'd0);
    check("reset_ready4", 64'(ready4), 64'd1);
    check("reset_valid4", 64'(vout4), 64'd0);
    rst_n = 1'b1;

    sel = 1'b0;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'd5, 32'd100, 32'd0, 0);
    do_op(3'd7, 32'd100, 32'd0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'd0, 32'h0001_0003, 32'h0000_0101, 5);
    do_op(3'd5, 32'hDEAD_BEEF, 32'd16, 0);
    random_ops(30);
    flush_test();
    do_op(3'd6, 32'h8765_4321, 32'h0000_1000, 0);
    reset_test();

    sel = 1'b1;
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
    do_op(3'd5, 32'd100, 32'd0, 0);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 2);
    random_ops(15);
    flush_test();
    do_op(3'd4, 32'hFFFF_FF00, 32'd7, 0);
    reset_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
